// File: rtl/stream_mux_pkg.sv
// Shared constants for the N:1 stream mux and its arbiter.
package stream_mux_pkg;

  localparam logic        MODE_MANUAL = 1'b0;
  localparam logic        MODE_RR     = 1'b1;
  localparam int unsigned XFER_CNT_W  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  int unsigned idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!gnt_valid && req[IW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// N:1 valid/ready stream mux with manual or round-robin selection and a registered output.
// Optional transfer counter port xfer_cnt enabled by STREAM_MUX_XFER_CNT_EN.
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_ch
`ifdef STREAM_MUX_XFER_CNT_EN
  ,
  output logic [XFER_CNT_W-1:0]     xfer_cnt
`endif
);

  localparam int unsigned PAD_N = 1 << SEL_W;

  logic [SEL_W-1:0] ptr;
  logic [PAD_N-1:0] valid_pad;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;

  // Padding to a power of two makes out-of-range manual selects read as "not valid".
  assign valid_pad = PAD_N'(in_valid);

  rr_arbiter #(.N(CHANNELS)) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (mode == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else begin
      gnt_valid = valid_pad[sel];
      gnt_idx   = sel;
    end
    if (rst) gnt_valid = 1'b0;
  end

  assign load = !out_valid || out_ready;
  assign xfer = load && gnt_valid;

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register and fairness pointer; pointer moves only on an accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      out_data  <= gnt_data;
      out_ch    <= gnt_idx;
      out_valid <= 1'b1;
      ptr       <= (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUX_XFER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + XFER_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Scoreboard bench for stream_mux_nto1 (4 channels x 8 bits); counter test when STREAM_MUX_XFER_CNT_EN is set.
module tb_stream_mux_nto1;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned SW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid = '0;
  logic [CH-1:0]   in_ready;
  logic            mode = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SW-1:0]   out_ch;
`ifdef STREAM_MUX_XFER_CNT_EN
  logic [15:0]     xfer_cnt;
`endif

  logic [W-1:0] ch_data [CH];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [SW-1:0]    m_ptr = '0;
  logic             m_valid = 1'b0;
  logic [SW+W-1:0]  sb_q[$];
  logic [15:0]      m_cnt = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < CH; i++) in_data[i*W +: W] = ch_data[i];
  end

  stream_mux_nto1 #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef STREAM_MUX_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  task automatic model_grant(output logic gv, output int g);
    logic [2*CH-1:0] dbl;
    gv = 1'b0;
    g  = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < CH && in_valid[sel]) begin
        gv = 1'b1;
        g  = int'(sel);
      end
    end else begin
      dbl = {in_valid, in_valid};
      for (int k = CH - 1; k >= 0; k--) begin
        if (dbl[int'(m_ptr) + k]) begin
          gv = 1'b1;
          g  = (int'(m_ptr) + k) % CH;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_ptr   = '0;
    m_valid = 1'b0;
    m_cnt   = '0;
    sb_q.delete();
  endtask

  // One clock: called at a negedge with inputs already driven; checks, then advances the model.
  task automatic step();
    logic load, gv, xfer, drain;
    int g;
    logic [CH-1:0] exp_ready;
    logic [SW+W-1:0] exp_word;
    #1;
    load = !m_valid || out_ready;
    model_grant(gv, g);
    xfer = load && gv;
    exp_ready = xfer ? CH'(1 << g) : '0;
    vectors++;
    if (in_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
    end
    vectors++;
    if (out_valid !== m_valid) begin
      miscompares++;
      $display("FAIL out_valid: got %b expected %b", out_valid, m_valid);
    end
    drain = m_valid && out_ready;
    if (m_valid) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: got output word expected none queued");
      end else begin
        exp_word = drain ? sb_q.pop_front() : sb_q[0];
        if ({out_ch, out_data} !== exp_word) begin
          miscompares++;
          $display("FAIL out_word: got ch%0d/%h expected ch%0d/%h",
                   out_ch, out_data, exp_word[SW+W-1:W], exp_word[W-1:0]);
        end
      end
    end
    if (xfer) begin
      sb_q.push_back({SW'(g), ch_data[g]});
      m_ptr = (g == CH - 1) ? '0 : SW'(g + 1);
    end
    @(posedge clk);
    if (drain) m_cnt = m_cnt + 16'd1;
    m_valid = xfer ? 1'b1 : (drain ? 1'b0 : m_valid);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < CH; i++) ch_data[i] = 8'h30 + W'(i);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    vectors++;
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out_data: got %h expected 00", out_data); end
    vectors++;
    if (out_ch !== 2'd0) begin miscompares++; $display("FAIL rst_out_ch: got %0d expected 0", out_ch); end
    vectors++;
    if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 0000", in_ready); end
    rst = 1'b0;
    model_reset();
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h30) begin
      miscompares++;
      $display("FAIL first_word: got v=%b d=%h expected v=1 d=30", out_valid, out_data);
    end
  endtask

  task automatic test_manual();
    mode       = 1'b0;
    sel        = 2'd2;
    ch_data[2] = 8'hA5;
    in_valid   = 4'b0100;
    out_ready  = 1'b1;
    step();
    vectors++;
    if (out_data !== 8'hA5 || out_ch !== 2'd2) begin
      miscompares++;
      $display("FAIL manual_word: got ch%0d/%h expected ch2/a5", out_ch, out_data);
    end
    sel = 2'd3;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL manual_drop: got %b expected 0", out_valid); end
    step();
  endtask

  task automatic test_rr_fair();
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < CH; i++) ch_data[i] = 8'h10 + W'(i);
    for (int n = 0; n < 6; n++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || int'(out_ch) != exp_seq[n] || out_data !== 8'h10 + W'(exp_seq[n])) begin
        miscompares++;
        $display("FAIL rr_fair[%0d]: got v=%b ch%0d/%h expected ch%0d", n, out_valid, out_ch, out_data, exp_seq[n]);
      end
    end
  endtask

  task automatic test_rr_skip();
    int exp_seq [4] = '{1, 3, 1, 3};
    do_reset();
    mode     = 1'b1;
    in_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      step();
      vectors++;
      if (int'(out_ch) != exp_seq[n]) begin
        miscompares++;
        $display("FAIL rr_skip[%0d]: got ch%0d expected ch%0d", n, out_ch, exp_seq[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    held      = out_data;
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      ch_data[n % CH] = 8'hC0 + W'(n);
      step();
      vectors++;
      if (out_data !== held) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got %h expected %h", n, out_data, held);
      end
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_no_bubble: got %b expected 1", out_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got %b expected 1", out_valid); end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b d=%h ch=%0d rdy=%b expected 0/00/0/0000", out_valid, out_data, out_ch, in_ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
  endtask

`ifdef STREAM_MUX_XFER_CNT_EN
  task automatic test_xfer_cnt();
    do_reset();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    for (int n = 0; n < 3; n++) step();
    in_valid = 4'b0000;
    step();
    step();
    vectors++;
    if (xfer_cnt !== 16'd3) begin miscompares++; $display("FAIL xfer_cnt_3: got %0d expected 3", xfer_cnt); end
    in_valid = 4'b1111;
    for (int n = 0; n < 65533; n++) step();
    in_valid = 4'b0000;
    step();
    step();
    vectors++;
    if (xfer_cnt !== 16'd0 || m_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL xfer_cnt_wrap: got %0d expected 0", xfer_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_manual();
    test_rr_fair();
    test_rr_skip();
    test_backpressure();
    test_reset_mid();
`ifdef STREAM_MUX_XFER_CNT_EN
    test_xfer_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
